// File: rtl/seg_pkg.sv
// Shared constants, types and helpers for the scrolling seven-segment display.
package seg_pkg;

  localparam int unsigned SEG_W  = 7;
  localparam int unsigned AN_W   = 4;
  localparam int unsigned SEL_W  = 2;
  localparam int unsigned FILL_W = 3;

  typedef logic [SEG_W-1:0] seg_t;
  typedef logic [AN_W-1:0]  an_t;

  // One registered display drive: segments plus anodes, both active-low.
  typedef struct packed {
    seg_t seg;
    an_t  an;
  } drive_t;

  localparam seg_t SEG_BLANK = 7'b1111111;
  localparam an_t  ANODE_OFF = 4'b1111;

  // Letter codes, active-low, bit order gfedcba.
  localparam seg_t SEG_U    = 7'b1000001;
  localparam seg_t SEG_A    = 7'b0001000;
  localparam seg_t SEG_B    = 7'b0000011;
  localparam seg_t SEG_C    = 7'b1000110;
  localparam seg_t SEG_DASH = 7'b0111111;
  localparam seg_t SEG_E    = 7'b0000110;
  localparam seg_t SEG_L    = 7'b1000111;
  localparam seg_t SEG_T    = 7'b0000111;
  localparam seg_t SEG_R    = 7'b0101111;
  localparam seg_t SEG_O    = 7'b1000000;
  localparam seg_t SEG_N    = 7'b0101011;
  localparam seg_t SEG_I    = 7'b1111001;

  function automatic an_t an_onehot_low(input logic [SEL_W-1:0] sel);
    return ~(an_t'(1) << sel);
  endfunction

endpackage

// File: rtl/seg_scroll_mux_if.sv
// Character push / display drive bundle between a producer and seg_scroll_mux.
interface seg_scroll_mux_if;
  import seg_pkg::*;

  seg_t seg_in;
  logic seg_valid;
  logic clear;
  logic enable;
  seg_t seg_out;
  an_t  an_out;
  logic full;

  modport master (
    output seg_in, seg_valid, clear, enable,
    input  seg_out, an_out, full
  );

  modport slave (
    input  seg_in, seg_valid, clear, enable,
    output seg_out, an_out, full
  );

endinterface

// File: rtl/refresh_timer.sv
// Digit-slot timer: refresh counter, digit select and blank-interval flag,
// both frozen while the display is disabled.
module refresh_timer #(
  parameter int unsigned REFRESH_DIV  = 25_000,
  parameter int unsigned BLANK_CYCLES = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable_i,
  output logic [1:0] sel_o,
  output logic       blank_c
);

  localparam int unsigned CNT_W = $clog2(REFRESH_DIV);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       sel_q, sel_d;

  always_comb begin
    cnt_d = cnt_q;
    sel_d = sel_q;
    if (enable_i) begin
      if (cnt_q == CNT_W'(REFRESH_DIV - 1)) begin
        cnt_d = '0;
        sel_d = sel_q + 2'd1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      sel_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      sel_q <= sel_d;
    end
  end

  assign sel_o   = sel_q;
  assign blank_c = (cnt_q < CNT_W'(BLANK_CYCLES));

endmodule

// File: rtl/seg_scroll_mux.sv
// Four-digit scrolling character buffer multiplexed onto a common-anode
// seven-segment display with an anti-ghosting blank at the start of each slot.
module seg_scroll_mux
  import seg_pkg::*;
#(
  parameter int unsigned REFRESH_DIV  = 25_000,
  parameter int unsigned BLANK_CYCLES = 64
) (
  input  logic             clk,
  input  logic             rst,
  seg_scroll_mux_if.slave  bus
);

  seg_t [3:0]        dig_q, dig_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic              full_q;
  drive_t            drv_q, drv_d;
  logic [SEL_W-1:0]  sel;
  logic              blank_c;

  refresh_timer #(
    .REFRESH_DIV  (REFRESH_DIV),
    .BLANK_CYCLES (BLANK_CYCLES)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .enable_i (bus.enable),
    .sel_o    (sel),
    .blank_c  (blank_c)
  );

  // Scroll buffer: clear wins over a same-cycle push.
  always_comb begin
    dig_d  = dig_q;
    fill_d = fill_q;
    if (bus.clear) begin
      dig_d  = {4{SEG_BLANK}};
      fill_d = '0;
    end else if (bus.seg_valid) begin
      dig_d = {dig_q[2:0], bus.seg_in};
      if (fill_q != FILL_W'(4)) begin
        fill_d = fill_q + FILL_W'(1);
      end
    end
  end

  // Next display drive from the current slot and buffer.
  always_comb begin
    drv_d.seg = SEG_BLANK;
    drv_d.an  = ANODE_OFF;
    if (bus.enable && !blank_c) begin
      drv_d.seg = dig_q[sel];
      drv_d.an  = an_onehot_low(sel);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dig_q  <= {4{SEG_BLANK}};
      fill_q <= '0;
      full_q <= 1'b0;
      drv_q  <= '{seg: SEG_BLANK, an: ANODE_OFF};
    end else begin
      dig_q  <= dig_d;
      fill_q <= fill_d;
      full_q <= (fill_d == FILL_W'(4));
      drv_q  <= drv_d;
    end
  end

  assign bus.seg_out = drv_q.seg;
  assign bus.an_out  = drv_q.an;
  assign bus.full    = full_q;

endmodule

// File: doc/seg_scroll_mux.md
SEG_SCROLL_MUX -- requirements
Module: seg_scroll_mux

Interface
REQ-001 SHALL have parameter REFRESH_DIV, default 25_000: clk cycles each digit is scanned (minimum 4).
REQ-002 SHALL have parameter BLANK_CYCLES, default 64: cycles at the start of each digit slot with all anodes off, for anti-ghosting (must be less than REFRESH_DIV).
REQ-003 SHALL have port clk, input, 1: the single clock; all state is on the rising edge.
REQ-004 SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-005 SHALL have port seg_in, input, 7: character segment code, active-low, bit order gfedcba.
REQ-006 SHALL have port seg_valid, input, 1: one-cycle strobe that pushes seg_in into the scroll buffer.
REQ-007 SHALL have port clear, input, 1: synchronous flush of the buffer to blank.
REQ-008 SHALL have port enable, input, 1: display on when high.
REQ-009 SHALL have port seg_out, output, 7: registered segment drive, active-low.
REQ-010 SHALL have port an_out, output, 4: registered anode drive, active-low; bit 0 is the rightmost digit.
REQ-011 SHALL have port full, output, 1: high once 4 or more characters have been pushed since reset or clear.

Function
REQ-012 SHALL hold a 4-entry buffer d0..d3 (d0 rightmost); on seg_valid: d3<=d2, d2<=d1, d1<=d0, d0<=seg_in, visible in the buffer the next cycle.
REQ-013 SHALL hold a 3-bit fill count: +1 per push, saturating at 4; full = (fill==4).
REQ-014 SHALL give clear priority over a simultaneous seg_valid: all entries become SEG_BLANK (7'b1111111), fill becomes 0, and the push is dropped.
REQ-015 SHALL run a refresh counter 0..REFRESH_DIV-1 that wraps; at each wrap a 2-bit digit select advances 0->1->2->3->0.
REQ-016 SHALL drive, while the refresh counter < BLANK_CYCLES: an_out=4'b1111 and seg_out=SEG_BLANK.
REQ-017 SHALL otherwise drive: an_out = one-hot-low of the digit select (digit 0 -> 4'b1110, digit 3 -> 4'b0111) and seg_out = d[select].
REQ-018 SHALL register outputs with one cycle of latency from the counter/select/buffer state.
REQ-019 SHALL, with enable low: hold the refresh counter and select, force an_out=4'b1111 and seg_out=SEG_BLANK; pushes and clear still act on the buffer.
REQ-020 SHALL, when enable rises: resume scanning from the held counter and select values with no restart.
REQ-021 SHALL show a buffer change to the currently lit digit from the next cycle (no wait for the slot boundary).

Reset
REQ-022 SHALL, on rst: d0..d3 = SEG_BLANK, fill=0, refresh counter=0, select=0, an_out=4'b1111, seg_out=7'b1111111, full=0, all immediately (asynchronous).
REQ-023 SHALL restart scanning at digit 0 with a blank interval after rst deasserts.

Structure
REQ-024 SHALL take constants SEG_BLANK, ANODE_OFF (4'b1111) and the letter codes (U, A, B, C, -, E, L, T, R, O, N, I) from shared package seg_pkg.
REQ-025 SHALL contain one sub-module, refresh_timer (refresh counter, digit select, blank flag, enable hold), parameterised by REFRESH_DIV and BLANK_CYCLES.

Verification (REFRESH_DIV=8, BLANK_CYCLES=2)
REQ-026 SHALL cover reset mid-scan: assert rst during a digit-2 slot -> an_out=4'b1111 and seg_out=7'b1111111 in the same cycle, without a clock edge; after release, first lit anode is 4'b1110.
REQ-027 SHALL cover push and scroll: push U(1000001), A(0001000), B(0000011), C(1000110) -> d3..d0 = U,A,B,C and full=1; a fifth push of '-' (0111111) -> d3..d0 = A,B,C,-.
REQ-028 SHALL cover the scan pattern: over 32 cycles each anode pattern 1110, 1101, 1011, 0111 is lit for 6 cycles, preceded by 2 blank cycles, with seg_out matching the digit.
REQ-029 SHALL cover clear with a simultaneous push: seg_valid=1 and clear=1 in the same cycle -> all digits blank, fill=0, full=0.
REQ-030 SHALL cover enable gating: deassert enable mid-slot for 10 cycles -> anodes off; push E during that window; re-enable -> the same slot resumes at its held count and E is shown on digit 0 at its next slot.
